// File: rtl/m68k_bus_sequencer.sv
// 68000 asynchronous bus sequencer: strobe sync, region decode, wait states, DTACK/BERR.
// Define M68K_BUS_WATCHDOG_EN to end unmapped or stalled cycles with BERR.
module m68k_bus_sequencer #(
    parameter int WAIT_ROM = 2,
    parameter int WAIT_RAM = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw,
    input  logic [23:0] addr,
    input  logic        dev_ready,
    output logic        dtack_n,
    output logic        berr_n,
    output logic [1:0]  dev_sel,
    output logic        dev_req,
    output logic        dev_we,
    output logic [1:0]  dev_be,
    output logic [22:0] dev_addr,
    output logic        data_oe
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERR} state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_ROM  = 2'd1;
    localparam logic [1:0] SEL_RAM  = 2'd2;
    localparam logic [1:0] SEL_IO   = 2'd3;
    localparam logic [7:0] WAIT_ROM_L = 8'(WAIT_ROM);
    localparam logic [7:0] WAIT_RAM_L = 8'(WAIT_RAM);
`ifdef M68K_BUS_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    function automatic logic [1:0] region(input logic [3:0] hi);
        case (hi)
            4'h0:    return SEL_ROM;
            4'h1:    return SEL_RAM;
            4'hF:    return SEL_IO;
            default: return SEL_NONE;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync2_q;   // {as_n, uds_n, lds_n, rw}
    logic [1:0]  vld_q;
    logic        as_prev_q;
    logic        armed_q, armed_d;
    logic [22:0] addr_q, addr_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  dev_sel_q, dev_sel_d;
    logic        dev_we_q, dev_we_d;
    logic [1:0]  dev_be_q, dev_be_d;
    logic [22:0] dev_addr_q, dev_addr_d;
    logic        dev_req_q, dev_req_d;
    logic        dtack_n_q, dtack_n_d;
    logic        data_oe_q, data_oe_d;
    logic        timeout;
    logic        unused_a0;

    wire as_s   = sync2_q[3];
    wire uds_s  = sync2_q[2];
    wire lds_s  = sync2_q[1];
    wire rw_s   = sync2_q[0];
    wire as_vld = vld_q[1];
    wire as_edge = !as_s && as_prev_q;

    assign unused_a0 = addr[0];

`ifdef M68K_BUS_WATCHDOG_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       berr_n_q, berr_n_d;

    // Counts cycles since DECODE (zero while IDLE), saturating at all-ones.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_IDLE)
            tmo_d = 8'd0;
        else if (tmo_q != 8'hFF)
            tmo_d = tmo_q + 8'd1;
        berr_n_d = (state_d != S_ERR);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tmo_q    <= 8'd0;
            berr_n_q <= 1'b1;
        end else begin
            tmo_q    <= tmo_d;
            berr_n_q <= berr_n_d;
        end
    end

    assign timeout = (tmo_q >= TMO_LIM);
    assign berr_n  = berr_n_q;
`else
    assign timeout = 1'b0;
    assign berr_n  = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        addr_d     = as_edge ? addr[23:1] : addr_q;
        wait_d     = wait_q;
        dev_sel_d  = dev_sel_q;
        dev_we_d   = dev_we_q;
        dev_be_d   = dev_be_q;
        dev_addr_d = dev_addr_q;
        dev_req_d  = 1'b0;
        // A new cycle is only accepted after AS has been seen high since the last one.
        if (as_vld && as_s)
            armed_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (armed_q && !as_s && (rw_s || !uds_s || !lds_s)) begin
                    state_d    = S_DECODE;
                    armed_d    = 1'b0;
                    dev_sel_d  = region(addr_d[22:19]);
                    dev_we_d   = !rw_s;
                    dev_be_d   = {!uds_s, !lds_s};
                    dev_addr_d = addr_d;
                    dev_req_d  = (dev_sel_d != SEL_NONE);
                end
            end
            S_DECODE: begin
                wait_d = (dev_sel_q == SEL_ROM) ? WAIT_ROM_L : WAIT_RAM_L;
                if (as_s)
                    state_d = S_IDLE;
                else if (dev_sel_q == SEL_NONE)
                    state_d = WD_EN ? S_ERR : S_ACK;
                else if (dev_sel_q == SEL_IO || wait_d != 8'd0)
                    state_d = S_WAIT;
                else
                    state_d = S_ACK;
            end
            S_WAIT: begin
                if (dev_sel_q != SEL_IO)
                    wait_d = wait_q - 8'd1;
                if (as_s)
                    state_d = S_IDLE;
                else if ((dev_sel_q == SEL_IO) ? dev_ready : (wait_d == 8'd0))
                    state_d = S_ACK;
                else if (timeout)
                    state_d = S_ERR;
            end
            S_ACK, S_ERR: begin
                if (as_s)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            dev_sel_d  = SEL_NONE;
            dev_we_d   = 1'b0;
            dev_be_d   = 2'b00;
            dev_addr_d = 23'd0;
        end
        dtack_n_d = (state_d != S_ACK);
        data_oe_d = (state_d == S_ACK) && !dev_we_d && (dev_sel_d != SEL_NONE);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync1_q    <= 4'b1111;
            sync2_q    <= 4'b1111;
            vld_q      <= 2'b00;
            as_prev_q  <= 1'b1;
            armed_q    <= 1'b0;
            addr_q     <= 23'd0;
            state_q    <= S_IDLE;
            wait_q     <= 8'd0;
            dev_sel_q  <= SEL_NONE;
            dev_we_q   <= 1'b0;
            dev_be_q   <= 2'b00;
            dev_addr_q <= 23'd0;
            dev_req_q  <= 1'b0;
            dtack_n_q  <= 1'b1;
            data_oe_q  <= 1'b0;
        end else begin
            sync1_q    <= {as_n, uds_n, lds_n, rw};
            sync2_q    <= sync1_q;
            vld_q      <= {vld_q[0], 1'b1};
            as_prev_q  <= as_s;
            armed_q    <= armed_d;
            addr_q     <= addr_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
            dev_sel_q  <= dev_sel_d;
            dev_we_q   <= dev_we_d;
            dev_be_q   <= dev_be_d;
            dev_addr_q <= dev_addr_d;
            dev_req_q  <= dev_req_d;
            dtack_n_q  <= dtack_n_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign dtack_n  = dtack_n_q;
    assign dev_sel  = dev_sel_q;
    assign dev_req  = dev_req_q;
    assign dev_we   = dev_we_q;
    assign dev_be   = dev_be_q;
    assign dev_addr = dev_addr_q;
    assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Randomized bus-cycle bench for m68k_bus_sequencer against a cycle-count reference model.
module tb_m68k_bus_sequencer;
    localparam int WROM = 2;
    localparam int WRAM = 0;
    localparam int TMO  = 255;
`ifdef M68K_BUS_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk_sys = 1'b0, rst = 1'b1;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1, dev_ready = 1'b0;
    logic [23:0] addr = 24'd0;
    logic        dtack_n, berr_n, dev_req, dev_we, data_oe;
    logic [1:0]  dev_sel, dev_be;
    logic [22:0] dev_addr;

    int checks = 0, errors = 0;

    always #10 clk_sys = ~clk_sys;

    m68k_bus_sequencer #(.WAIT_ROM(WROM), .WAIT_RAM(WRAM), .TIMEOUT(TMO)) dut (
        .clk_sys(clk_sys), .rst(rst), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
        .addr(addr), .dev_ready(dev_ready), .dtack_n(dtack_n), .berr_n(berr_n),
        .dev_sel(dev_sel), .dev_req(dev_req), .dev_we(dev_we), .dev_be(dev_be),
        .dev_addr(dev_addr), .data_oe(data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [23:0] a;
        bit rw, uds, lds;
        int rdy, abrt, hold, gap;
    } txn_t;

    txn_t tq[$];
    int   pre  = 0;
    int   reqs = 0;

    function automatic int exp_sel(input logic [23:0] a);
        case (a[23:20])
            4'h0:    return 1;
            4'h1:    return 2;
            4'hF:    return 3;
            default: return 0;
        endcase
    endfunction

    // Cycles counted from the negedge AS is driven low: DECODE is seen 3 cycles later
    // (two sync flops + accept), ACK one cycle after the last wait state or after dev_ready.
    // kind: 0 no response (aborted), 1 DTACK, 2 BERR.
    function automatic void model(input txn_t t, output int rn, output int kind);
        int s;
        s = exp_sel(t.a);
        kind = 1;
        case (s)
            1:       rn = 4 + WROM;
            2:       rn = 4 + WRAM;
            3:       rn = (t.rdy < 0) ? 100000 : 4 + t.rdy;
            default: begin rn = 4; if (WD) kind = 2; end
        endcase
        if (WD && rn > 3 + TMO) begin rn = 3 + TMO; kind = 2; end
        if (t.abrt > 0 && t.abrt + 3 <= rn) kind = 0;
    endfunction

    task automatic drive_start(input txn_t t);
        addr = t.a; rw = t.rw; uds_n = t.uds; lds_n = t.lds; as_n = 1'b0;
    endtask

    task automatic samp(input txn_t t, input int n);
        int s;
        s = exp_sel(t.a);
        if (dev_req === 1'b1) reqs++;
        if (n == 3) begin
            chk("dec_req",  dev_req, s != 0);
            chk("dec_sel",  dev_sel, s);
            chk("dec_we",   dev_we, !t.rw);
            chk("dec_be",   dev_be, {!t.uds, !t.lds});
            chk("dec_addr", dev_addr, t.a[23:1]);
        end
    endtask

    task automatic run_txn(input int i);
        txn_t t;
        int n, rn, kind, s, got_n, got_kind;
        bit done, oe;
        t = tq[i];
        n = pre; got_n = -1; got_kind = 0; done = 0; oe = 0; reqs = 0;
        s = exp_sel(t.a);
        model(t, rn, kind);
        while (!done && n < 400) begin
            @(negedge clk_sys); n++;
            samp(t, n);
            if (dtack_n === 1'b0 || berr_n === 1'b0) begin
                got_n = n; oe = data_oe; done = 1;
                got_kind = (dtack_n === 1'b0 && berr_n === 1'b0) ? 3 : (dtack_n === 1'b0) ? 1 : 2;
            end else if (t.abrt > 0 && n == t.abrt) begin
                as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; done = 1;
            end else if (s == 3) begin
                dev_ready = (t.rdy > 0 && n >= 3 + t.rdy);
            end else begin
                dev_ready = 1'($urandom_range(0, 1));
            end
        end
        dev_ready = 1'b0;
        chk("resp_kind", got_kind, kind);
        if (kind != 0) chk("resp_cyc", got_n, rn);
        if (kind == 1) chk("data_oe", oe, t.rw && s != 0);
        if (kind != 0 && got_kind != 0) begin
            repeat (t.hold) begin
                @(negedge clk_sys); n++;
                samp(t, n);
                chk("hold", {dtack_n, berr_n}, (kind == 1) ? 2'b01 : 2'b10);
            end
            as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        end
        for (int g = 1; g <= 3; g++) begin
            @(negedge clk_sys); n++;
            samp(t, n);
            if (kind == 0) chk("abort_quiet", {dtack_n, berr_n}, 2'b11);
            else if (g == 2) chk("rel_hold", {dtack_n, berr_n}, (kind == 1) ? 2'b01 : 2'b10);
            if (g == 3) begin
                chk("rel_dtack", dtack_n, 1'b1);
                chk("rel_berr",  berr_n, 1'b1);
                chk("rel_sel",   dev_sel, 2'd0);
                chk("rel_oe",    data_oe, 1'b0);
            end
            if (g == t.gap && i + 1 < tq.size()) drive_start(tq[i + 1]);
        end
        chk("req_cnt", reqs, s != 0);
        pre = 3 - t.gap;
    endtask

    function automatic txn_t mk(input logic [23:0] a, input bit r, input bit u, input bit l,
                                input int rdy, input int abrt, input int hold, input int gap);
        txn_t t;
        t.a = a; t.rw = r; t.uds = u; t.lds = l;
        t.rdy = rdy; t.abrt = abrt; t.hold = hold; t.gap = gap;
        return t;
    endfunction

    initial begin
        int cnt, k;
        txn_t t;
        logic [3:0] top;
        logic [1:0] be;

        repeat (3) @(negedge clk_sys);
        chk("rst_dtack", dtack_n, 1'b1);
        chk("rst_berr",  berr_n, 1'b1);
        chk("rst_sel",   dev_sel, 2'd0);
        chk("rst_req",   dev_req, 1'b0);
        chk("rst_we",    dev_we, 1'b0);
        chk("rst_be",    dev_be, 2'd0);
        chk("rst_addr",  dev_addr, 23'd0);
        chk("rst_oe",    data_oe, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk_sys);

        tq.push_back(mk(24'h000100, 1, 0, 0, 0, 0, 2, 3));
        tq.push_back(mk(24'h100002, 0, 1, 0, 0, 0, 1, 2));
        tq.push_back(mk(24'hF00000, 1, 0, 0, 10, 0, 0, 3));
        tq.push_back(mk(24'h500000, 1, 0, 0, 0, 0, 1, 3));
        tq.push_back(mk(24'h000200, 1, 0, 0, 0, 2, 0, 1));
        tq.push_back(mk(24'h000204, 1, 0, 0, 0, 0, 0, 1));
`ifdef M68K_BUS_WATCHDOG_EN
        tq.push_back(mk(24'hF00010, 1, 0, 0, -1, 0, 0, 3));
`endif
        for (int r = 0; r < 40; r++) begin
            k = $urandom_range(0, 3);
            top = (k == 0) ? 4'h0 : (k == 1) ? 4'h1 : (k == 2) ? 4'hF : 4'($urandom_range(2, 14));
            be = 2'($urandom_range(1, 3));
            t = mk({top, 20'($urandom)}, 1'($urandom_range(0, 1)), !be[1], !be[0],
                   $urandom_range(1, 20), 0, $urandom_range(0, 2), $urandom_range(1, 3));
            if (top == 4'h0 && $urandom_range(0, 5) == 0) begin
                t.abrt = $urandom_range(2, 3);
                tq[tq.size() - 1].gap = 3;
            end
            tq.push_back(t);
        end

        drive_start(tq[0]);
        pre = 0;
        for (int i = 0; i < tq.size(); i++) run_txn(i);

        // Reset while DTACK is asserted, AS still held low afterwards.
        drive_start(mk(24'h000000, 1, 0, 0, 0, 0, 0, 3));
        cnt = 0;
        while (dtack_n !== 1'b0 && cnt < 50) begin
            @(negedge clk_sys); cnt++;
        end
        chk("rt_ack", dtack_n, 1'b0);
        rst = 1'b1;
        @(negedge clk_sys);
        chk("rt_dtack", dtack_n, 1'b1);
        chk("rt_sel", dev_sel, 2'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk_sys);
            if (dtack_n !== 1'b1 || dev_req !== 1'b0) cnt++;
        end
        chk("rt_quiet", cnt, 0);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        tq.push_back(mk(24'h100010, 1, 0, 1, 0, 0, 1, 3));
        drive_start(tq[tq.size() - 1]);
        pre = 0;
        run_txn(tq.size() - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m68k_bus_sequencer.md
M68K_BUS_SEQUENCER -- requirements
Module: m68k_bus_sequencer

Interface
REQ-001 SHALL have parameter WAIT_ROM, default 2: extra clk_sys cycles inserted before DTACK for ROM-region cycles.
REQ-002 SHALL have parameter WAIT_RAM, default 0: extra clk_sys cycles before DTACK for RAM-region cycles.
REQ-003 SHALL have parameter TIMEOUT, default 255: clk_sys cycles from decode to bus error (8-bit counter).
REQ-004 clk_sys  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 as_n, uds_n, lds_n, rw  in  1 each  raw asynchronous 68000 strobes.
REQ-007 addr  in  24  raw 68000 address; A0 is implied by uds_n/lds_n.
REQ-008 dev_ready  in  1  selected device has completed the access (IO region only).
REQ-009 dtack_n  out  1  68000 DTACK, active low.
REQ-010 berr_n  out  1  68000 BERR, active low.
REQ-011 dev_sel  out  2  region select: 0 none, 1 ROM, 2 RAM, 3 IO.
REQ-012 dev_req  out  1  single-cycle access strobe to the selected device.
REQ-013 dev_we, dev_be, dev_addr  out  1, 2, 23  write flag (~rw), byte enables {~uds,~lds}, word address A[23:1].
REQ-014 data_oe  out  1  enables the FPGA data-bus driver (read cycle, ACK state only).

Function
REQ-015 SHALL synchronize as_n, uds_n, lds_n and rw through two flops; addr SHALL be captured on the clock where synchronized AS first reads asserted.
REQ-016 Decode: A[23:20]=0x0 -> ROM; 0x1 -> RAM; 0xF -> IO; all other values -> unmapped.
REQ-017 FSM states: IDLE, DECODE, WAIT, ACK, ERR.
REQ-018 IDLE -> DECODE on the synchronized AS asserting edge, and only when at least one synchronized data strobe is asserted or rw=1.
REQ-019 DECODE (1 cycle): latch dev_sel/dev_we/dev_be/dev_addr, pulse dev_req for exactly one cycle if mapped, load the wait counter, clear the timeout counter; go to WAIT.
REQ-020 WAIT: ROM/RAM -> ACK when the wait counter reaches 0 (WAIT_x=0 gives ACK on the cycle after DECODE); IO -> ACK on the first cycle dev_ready=1.
REQ-021 ACK: dtack_n=0; data_oe=rw; hold until synchronized AS deasserts, then -> IDLE with dtack_n=1 and dev_sel=0 on the same edge.
REQ-022 ERR: berr_n=0, dtack_n=1; hold until synchronized AS deasserts, then -> IDLE.
REQ-023 If AS deasserts in DECODE or WAIT (aborted cycle), SHALL return to IDLE without asserting DTACK or BERR.
REQ-024 dev_ready asserted outside WAIT, or for a non-IO region, SHALL be ignored.
REQ-025 Back-to-back cycles: a new AS asserting edge seen on the same cycle as the ACK->IDLE exit SHALL NOT be missed; IDLE is entered and the edge is honoured on the next cycle.
REQ-026 Timeout counter SHALL saturate, never wrap.

Reset
REQ-027 While rst=1: state=IDLE, dtack_n=1, berr_n=1, dev_sel=0, dev_req=0, dev_we=0, dev_be=0, dev_addr=0, data_oe=0, all counters and synchronizers cleared (strobes to deasserted).
REQ-028 Reset asserted mid-cycle SHALL release DTACK/BERR on the next clock; after reset the FSM SHALL wait for AS to be seen deasserted before accepting a new cycle.

Configuration
REQ-029 Macro M68K_BUS_WATCHDOG_EN defined: unmapped cycles go DECODE -> ERR; any WAIT lasting TIMEOUT cycles -> ERR.
REQ-030 Macro undefined: no timeout counter, berr_n is tied to 1, unmapped cycles go DECODE -> ACK with data_oe=0, and IO WAIT waits indefinitely for dev_ready.

Verification
REQ-031 Read 0x000100, rw=1, both strobes -> dev_sel=1, one dev_req, dev_addr=0x000080, dtack_n low 3 cycles after DECODE, data_oe=1 until AS high.
REQ-032 Write 0x100002, lds only -> dev_sel=2, dev_we=1, dev_be=01, dtack_n low the cycle after DECODE, data_oe=0.
REQ-033 IO read 0xF00000 with dev_ready raised 10 cycles after dev_req -> dtack_n low the cycle after dev_ready.
REQ-034 With watchdog on: access 0x500000 -> berr_n low, dtack_n high, no dev_req; IO access with dev_ready never asserted -> berr_n low 255 cycles after DECODE. With watchdog off: access 0x500000 -> dtack_n low, data_oe=0, berr_n stays 1.
REQ-035 AS deasserted 1 cycle into ROM WAIT -> no DTACK, IDLE; a second cycle immediately after completes normally.
REQ-036 rst pulsed while in ACK -> dtack_n=1 next clock; no new cycle until AS is seen deasserted and then reasserted.
